// File: rtl/tank_ctrl.sv
// tank_ctrl: per-tank motion, clamp, fire cooldown and respawn control.
// Shot logic is built only when TANK_CTRL_FIRE_EN is defined.
module tank_ctrl #(
  parameter int         KEY_SLOTS   = 4,
  parameter logic [7:0] KEY_FWD     = 8'h52,
  parameter logic [7:0] KEY_BACK    = 8'h51,
  parameter logic [7:0] KEY_LEFT    = 8'h50,
  parameter logic [7:0] KEY_RIGHT   = 8'h4F,
  parameter logic [7:0] KEY_FIRE    = 8'h2C,
  parameter int         X_INIT      = 300,
  parameter int         Y_INIT      = 250,
  parameter int         X_MIN       = 0,
  parameter int         X_MAX       = 639,
  parameter int         Y_MIN       = 0,
  parameter int         Y_MAX       = 479,
  parameter int         SIZE        = 10,
  parameter int         SPEED       = 80,
  parameter int         FRAC_BITS   = 4,
  parameter int         ANGLE_STEPS = 45,
  parameter int         COOLDOWN    = 30,
  parameter int         RESPAWN     = 120
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [8*KEY_SLOTS-1:0] keycode,
  input  logic [7:0]             sin,
  input  logic [7:0]             cos,
  input  logic                   blocked,
  input  logic                   hit,
  output logic [9:0]             posX,
  output logic [9:0]             posY,
  output logic [9:0]             size,
  output logic [5:0]             angle,
  output logic                   fire,
  output logic                   alive
);

  localparam int PW = 10 + FRAC_BITS;
  localparam int AW = PW + 2;
  localparam int RW = (RESPAWN > 1) ? $clog2(RESPAWN) : 1;

  localparam logic signed [AW-1:0] X_LO = AW'((X_MIN + SIZE) << FRAC_BITS);
  localparam logic signed [AW-1:0] X_HI = AW'((X_MAX - SIZE) << FRAC_BITS);
  localparam logic signed [AW-1:0] Y_LO = AW'((Y_MIN + SIZE) << FRAC_BITS);
  localparam logic signed [AW-1:0] Y_HI = AW'((Y_MAX - SIZE) << FRAC_BITS);
  localparam logic [PW-1:0] X_RST = PW'(X_INIT << FRAC_BITS);
  localparam logic [PW-1:0] Y_RST = PW'(Y_INIT << FRAC_BITS);
  localparam logic [6:0]    SPD    = 7'(SPEED);
  localparam logic [5:0]    A_LAST = 6'(ANGLE_STEPS - 1);
  localparam logic [RW-1:0] R_LOAD = RW'(RESPAWN - 1);

  typedef enum logic {ACTIVE, DEAD} state_t;

  state_t           state;
  logic [PW-1:0]    px, py;
  logic [5:0]       ang;
  logic [RW-1:0]    resp;

  logic k_fwd, k_back, k_left, k_right, k_fire;
  logic mv_back, mv_left, mv_right, mv_move;
  logic [6:0]       mag_x, mag_y;
  logic signed [AW-1:0] dx, dy, step_x, step_y;
  logic [PW-1:0]    px_n, py_n;
  logic [5:0]       ang_inc, ang_dec;

  function automatic logic [PW-1:0] clamp_pos(
    input logic signed [AW-1:0] v,
    input logic signed [AW-1:0] lo,
    input logic signed [AW-1:0] hi
  );
    logic signed [AW-1:0] r;
    r = v;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    return r[PW-1:0];
  endfunction

  // A key is pressed when any slot carries its code
  always_comb begin
    k_fwd   = 1'b0;
    k_back  = 1'b0;
    k_left  = 1'b0;
    k_right = 1'b0;
    k_fire  = 1'b0;
    for (int i = 0; i < KEY_SLOTS; i++) begin
      if (keycode[8*i +: 8] == KEY_FWD)   k_fwd   = 1'b1;
      if (keycode[8*i +: 8] == KEY_BACK)  k_back  = 1'b1;
      if (keycode[8*i +: 8] == KEY_LEFT)  k_left  = 1'b1;
      if (keycode[8*i +: 8] == KEY_RIGHT) k_right = 1'b1;
      if (keycode[8*i +: 8] == KEY_FIRE)  k_fire  = 1'b1;
    end
  end

  // Motion priority, sub-pixel deltas, clamped targets, angle wrap
  always_comb begin
    mv_back  = k_back & ~k_fwd;
    mv_left  = k_left & ~k_fwd & ~k_back;
    mv_right = k_right & ~k_fwd & ~k_back & ~k_left;
    mv_move  = k_fwd | k_back;
    mag_x    = 7'((14'(SPD) * 14'(cos[6:0])) >> 7);
    mag_y    = 7'((14'(SPD) * 14'(sin[6:0])) >> 7);
    dx       = AW'(mag_x);
    dy       = AW'(mag_y);
    step_x   = (cos[7] ^ mv_back) ? -dx : dx;
    step_y   = (sin[7] ^ mv_back) ? dy : -dy;
    px_n     = clamp_pos($signed({2'b00, px}) + step_x, X_LO, X_HI);
    py_n     = clamp_pos($signed({2'b00, py}) + step_y, Y_LO, Y_HI);
    ang_inc  = (ang == A_LAST) ? 6'd0 : ang + 6'd1;
    ang_dec  = (ang == 6'd0) ? A_LAST : ang - 6'd1;
  end

  // Alive/dead FSM with position and heading state
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state <= ACTIVE;
      alive <= 1'b1;
      px    <= X_RST;
      py    <= Y_RST;
      ang   <= 6'd0;
      resp  <= '0;
    end else begin
      unique case (state)
        ACTIVE: begin
          if (hit) begin
            state <= DEAD;
            alive <= 1'b0;
            resp  <= R_LOAD;
          end else begin
            if (mv_move && !blocked) begin
              px <= px_n;
              py <= py_n;
            end
            if (mv_left)       ang <= ang_inc;
            else if (mv_right) ang <= ang_dec;
          end
        end
        DEAD: begin
          if (resp == '0) begin
            state <= ACTIVE;
            alive <= 1'b1;
            px    <= X_RST;
            py    <= Y_RST;
            ang   <= 6'd0;
          end else begin
            resp <= resp - 1'b1;
          end
        end
      endcase
    end
  end

`ifdef TANK_CTRL_FIRE_EN
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN - 1);

  logic [CW-1:0] cd;

  // One-frame shot pulse gated by a saturating cooldown
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      fire <= 1'b0;
      cd   <= '0;
    end else begin
      fire <= 1'b0;
      if (state == DEAD && resp == '0) begin
        cd <= '0;
      end else if (state == ACTIVE && k_fire && cd == '0 && !hit) begin
        fire <= 1'b1;
        cd   <= CD_LOAD;
      end else if (cd != '0) begin
        cd <= cd - 1'b1;
      end
    end
  end
`else
  logic unused_fire;
  assign unused_fire = k_fire;
  assign fire = 1'b0;
`endif

  assign posX  = px[PW-1:FRAC_BITS];
  assign posY  = py[PW-1:FRAC_BITS];
  assign angle = ang;
  assign size  = 10'(SIZE);

endmodule

// File: tb/tb_tank_ctrl.sv
// tb_tank_ctrl: directed vectors for tank_ctrl.
// Fire checks follow TANK_CTRL_FIRE_EN.
module tb_tank_ctrl;

  localparam logic [7:0] FW = 8'h52;
  localparam logic [7:0] BK = 8'h51;
  localparam logic [7:0] LT = 8'h50;
  localparam logic [7:0] RT = 8'h4F;
  localparam logic [7:0] FI = 8'h2C;
  localparam logic [7:0] NO = 8'h00;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] keycode = '0;
  logic [7:0]  sin = '0;
  logic [7:0]  cos = '0;
  logic        blocked = 1'b0;
  logic        hit = 1'b0;
  logic [9:0]  posX, posY, size;
  logic [5:0]  angle;
  logic        fire, alive;

  int n_vec = 0;
  int n_err = 0;

  tank_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .sin       (sin),
    .cos       (cos),
    .blocked   (blocked),
    .hit       (hit),
    .posX      (posX),
    .posY      (posY),
    .size      (size),
    .angle     (angle),
    .fire      (fire),
    .alive     (alive)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] kc(
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] c, input logic [7:0] d
  );
    return {d, c, b, a};
  endfunction

  task automatic frame(
    input logic [31:0] k, input logic [7:0] s,
    input logic [7:0] c, input logic b, input logic h
  );
    keycode = k;
    sin = s;
    cos = c;
    blocked = b;
    hit = h;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    keycode = '0;
    sin = '0;
    cos = '0;
    blocked = 1'b0;
    hit = 1'b0;
    Reset = 1'b1;
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_x", posX, 300);
    chk("rst_y", posY, 250);
    chk("rst_ang", angle, 0);
    chk("rst_alive", alive, 1);
    chk("rst_fire", fire, 0);
    chk("size", size, 10);

    // forward at angle 0: 4800 + 79 per frame
    frame(kc(NO, NO, NO, FW), 8'h00, 8'h7F, 0, 0);
    chk("fwd1_x", posX, 304);
    chk("fwd1_y", posY, 250);
    frame(kc(NO, NO, NO, FW), 8'h00, 8'h7F, 0, 0);
    chk("fwd2_x", posX, 309);

    do_reset();
    frame(kc(BK, NO, NO, NO), 8'h00, 8'h7F, 0, 0);
    chk("back_x", posX, 295);

    do_reset();
    frame(kc(NO, FW, NO, NO), 8'h7F, 8'h00, 0, 0);
    chk("up_x", posX, 300);
    chk("up_y", posY, 245);

    do_reset();
    frame(kc(NO, NO, FW, NO), 8'hC0, 8'hFF, 0, 0);
    chk("neg_x", posX, 295);
    chk("neg_y", posY, 252);

    // rotation wrap and motion priority
    do_reset();
    frame(kc(RT, NO, NO, NO), 8'h00, 8'h7F, 0, 0);
    chk("right_wrap", angle, 44);
    frame(kc(NO, LT, NO, NO), 8'h00, 8'h7F, 0, 0);
    chk("left_wrap", angle, 0);
    frame(kc(NO, NO, LT, NO), 8'h00, 8'h7F, 0, 0);
    chk("left_inc", angle, 1);
    frame(kc(LT, NO, FW, NO), 8'h00, 8'h7F, 0, 0);
    chk("prio_ang", angle, 1);
    chk("prio_x", posX, 304);
    frame(kc(RT, LT, NO, NO), 8'h00, 8'h7F, 0, 0);
    chk("left_over_right", angle, 2);

    // blocked and clamps
    do_reset();
    for (int i = 0; i < 3; i++)
      frame(kc(FW, NO, NO, NO), 8'h00, 8'h7F, 1, 0);
    chk("blocked_x", posX, 300);
    for (int i = 0; i < 80; i++)
      frame(kc(FW, NO, NO, NO), 8'h00, 8'h7F, 0, 0);
    chk("clamp_x", posX, 629);
    chk("clamp_y", posY, 250);
    frame(kc(BK, NO, NO, NO), 8'h00, 8'h7F, 0, 0);
    chk("clamp_frac_x", posX, 624);
    for (int i = 0; i < 60; i++)
      frame(kc(FW, NO, NO, NO), 8'h7F, 8'h00, 0, 0);
    chk("clamp_ylo", posY, 10);
    frame(kc(BK, NO, NO, NO), 8'h7F, 8'h00, 0, 0);
    chk("clamp_frac_y", posY, 14);

    // held fire: pulses on frames 1, 31, 61
    do_reset();
    for (int i = 1; i <= 65; i++) begin
      frame(kc(NO, NO, FI, NO), 8'h00, 8'h7F, 0, 0);
`ifdef TANK_CTRL_FIRE_EN
      chk($sformatf("fire_f%0d", i), fire,
          (i == 1 || i == 31 || i == 61) ? 1 : 0);
`else
      chk($sformatf("fire_f%0d", i), fire, 0);
`endif
    end
    // reset mid-cooldown clears the counter
    do_reset();
    chk("cd_rst_fire", fire, 0);
    frame(kc(FI, NO, NO, NO), 8'h00, 8'h7F, 0, 0);
`ifdef TANK_CTRL_FIRE_EN
    chk("cd_rst_shot", fire, 1);
`else
    chk("cd_rst_shot", fire, 0);
`endif

    // hit beats fire
    do_reset();
    frame(kc(FI, NO, NO, NO), 8'h00, 8'h7F, 0, 1);
    chk("hitfire_fire", fire, 0);
    chk("hitfire_alive", alive, 0);

    // death, ignored keys, respawn
    do_reset();
    frame(kc(FW, NO, NO, NO), 8'h00, 8'h7F, 0, 0);
    frame(kc(FW, NO, NO, NO), 8'h00, 8'h7F, 0, 0);
    frame(kc(LT, NO, NO, NO), 8'h00, 8'h7F, 0, 0);
    frame(kc(FW, NO, NO, NO), 8'h00, 8'h7F, 0, 1);
    chk("hit_alive", alive, 0);
    chk("hit_freeze_x", posX, 309);
    chk("hit_freeze_a", angle, 1);
    for (int i = 1; i <= 120; i++) begin
      frame(kc(FW, LT, FI, NO), 8'h00, 8'h7F, 0, i == 5);
      if (i == 60) begin
        chk("dead_x", posX, 309);
        chk("dead_a", angle, 1);
        chk("dead_fire", fire, 0);
      end
      if (i == 119) chk("dead_119", alive, 0);
    end
    chk("respawn_alive", alive, 1);
    chk("respawn_x", posX, 300);
    chk("respawn_y", posY, 250);
    chk("respawn_a", angle, 0);
    frame(kc(FW, NO, NO, NO), 8'h00, 8'h7F, 0, 0);
    chk("after_respawn_x", posX, 304);

    // reset during DEAD
    do_reset();
    frame(kc(FW, NO, NO, NO), 8'h00, 8'h7F, 0, 0);
    frame(kc(RT, NO, NO, NO), 8'h00, 8'h7F, 0, 1);
    for (int i = 0; i < 50; i++)
      frame(kc(NO, NO, NO, NO), 8'h00, 8'h7F, 0, 0);
    chk("pre_rst_alive", alive, 0);
    Reset = 1'b1;
    #1;
    chk("async_alive", alive, 1);
    chk("async_x", posX, 300);
    chk("async_y", posY, 250);
    chk("async_a", angle, 0);
    chk("async_fire", fire, 0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    frame(kc(FW, NO, NO, NO), 8'h00, 8'h7F, 0, 0);
    chk("post_rst_x", posX, 304);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tank_ctrl.md
# tank_ctrl

Parametrised per-player tank motion controller for the Tank Trouble game, one instance per tank. It decodes a multi-slot USB keycode word into rotate, translate and fire actions. It integrates sub-pixel position from an external sin/cos lookup, clamps the tank to the playfield, and honours a wall-blocked input from the collision checker. It also runs an alive/dead/respawn state machine with a fire cooldown, feeding the sprite renderer and the bullet manager.

## Interface
Parameters:
- KEY_SLOTS, 4: number of 8-bit keycode slots.
- KEY_FWD / KEY_BACK / KEY_LEFT / KEY_RIGHT / KEY_FIRE, 8'h52 / 8'h51 / 8'h50 / 8'h4F / 8'h2C: action keycodes.
- X_INIT, Y_INIT, 300, 250: spawn centre.
- X_MIN, X_MAX, Y_MIN, Y_MAX, 0, 639, 0, 479: playfield bounds.
- SIZE, 10: tank half-size in px.
- SPEED, 80: 7-bit speed magnitude.
- FRAC_BITS, 4: sub-pixel fraction bits.
- ANGLE_STEPS, 45: angle codes per revolution, max 64.
- COOLDOWN, 30: frames between shots.
- RESPAWN, 120: dead frames before respawn.

Ports:
- frame_clk  in  1  frame-rate clock (one edge per video frame).
- Reset  in  1  reset: asynchronous, active-high.
- keycode  in  8*KEY_SLOTS  pressed keys; 8'h00 means an empty slot.
- sin, cos  in  8 each  sign-magnitude values (bit7 = sign, [6:0] = Q0.7 magnitude) for the current angle output, looked up combinationally outside this block.
- blocked  in  1  collision checker reports that the pending translation hits a wall.
- hit  in  1  the tank was struck by a bullet this frame.
- posX, posY  out  10 each  integer centre position.
- size  out  10  constant SIZE.
- angle  out  6  heading code, 0..ANGLE_STEPS-1; 0 points to +X, increasing counter-clockwise.
- fire  out  1  one-frame shot request.
- alive  out  1  high in the ACTIVE state.

## Operation
- Key decode: a key is present if any slot equals its code. Motion priority is FWD > BACK > LEFT > RIGHT; only one motion action applies per frame. FIRE is decoded independently of motion.
- Delta magnitude: dX = (SPEED*cos[6:0])>>7 and dY = (SPEED*sin[6:0])>>7, both in units of 2^-FRAC_BITS px.
- FWD: X += ±dX using the sign of cos; Y -= ±dY using the sign of sin (screen Y points down).
- BACK: the negation of FWD.
- Position registers are 10+FRAC_BITS bits wide. posX and posY are the integer part.
- LEFT: angle+1, wrapping ANGLE_STEPS-1 to 0. RIGHT: angle-1, wrapping 0 to ANGLE_STEPS-1.
- blocked=1: the translation is discarded for that frame; rotation is unaffected.
- Clamp: the centre is limited to [X_MIN+SIZE, X_MAX-SIZE] and [Y_MIN+SIZE, Y_MAX-SIZE]. When a clamp applies, that axis's fraction is zeroed.
- FSM has two states, ACTIVE and DEAD.
  - ACTIVE + hit: go to DEAD. Load the respawn counter with RESPAWN-1. Freeze position and angle.
  - DEAD: ignore keys, hit and blocked; decrement the counter each frame.
  - DEAD with counter=0: go to ACTIVE. Position returns to spawn with fraction 0, angle=0, cooldown=0.
- Fire: in ACTIVE, with FIRE present, cooldown=0 and hit=0, assert fire for one frame and load cooldown with COOLDOWN-1. In any other frame, cooldown decrements toward 0 (saturating). Holding FIRE yields one pulse every COOLDOWN frames.
- hit and FIRE in the same frame: hit wins and no shot is fired.

## Timing
- All state updates on posedge frame_clk. Inputs are sampled at edge N and take effect in the outputs after edge N (1-frame latency).
- sin/cos must correspond to the angle output before the edge. The new angle's sin/cos are used from the next frame.
- Reset values: posX=X_INIT, posY=Y_INIT, fractions 0, angle=0, fire=0, alive=1, state ACTIVE, counters 0.
- Reset asserted mid-DEAD or mid-cooldown returns all state to the reset values immediately.
- fire is registered and lasts exactly one frame.

## Configuration
- TANK_CTRL_FIRE_EN defined: KEY_FIRE decode, cooldown counter and fire output are built as specified.
- TANK_CTRL_FIRE_EN undefined: no cooldown logic; fire is tied to 0; all other behaviour is unchanged.

## Test plan
- Reset, then FWD held at angle 0 (cos=8'h7F, sin=8'h00): delta 79/16 px per frame; posX=304 after 1 frame, 309 after 2; posY stays 250.
- RIGHT for 1 frame from reset: angle=44. LEFT for 1 frame from 44: angle=0. FWD and LEFT held together: translation only, angle unchanged.
- FWD at angle 0 held from X_INIT: posX saturates at 629 and holds; the fraction stays 0 once clamped. FWD with blocked=1: position unchanged.
- FIRE held for 65 frames (TANK_CTRL_FIRE_EN defined): fire pulses at frames 1, 31 and 61 only.
- hit in ACTIVE: alive=0 next frame and keys are ignored; after 120 frames alive=1, pos=(300,250), angle=0. Second hit while DEAD: no effect.
- Reset asserted during DEAD at frame 50: outputs immediately return to reset values; alive=1.
